// File: rtl/div_issue.sv
// div_issue: issue/collect controller between ID and the 64-bit iterative divider (RV64M DIV/REM[U][W]).
// Define DIV_ISSUE_CACHE_EN to keep the last collected divider result and reuse it on an exact key match.
module div_issue #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic             in_w,
    input  logic [XLEN-1:0]  in_src1,
    input  logic [XLEN-1:0]  in_src2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             div_id_valid,
    output logic             div_ena,
    output logic             div_signed,
    output logic             div_w,
    output logic [XLEN-1:0]  div_dividend,
    output logic [XLEN-1:0]  div_divisor,
    output logic             div_ex_ready,
    input  logic             div_valid,
    input  logic [XLEN-1:0]  div_quotient,
    input  logic [XLEN-1:0]  div_remainder,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LAUNCH = 3'd1,
        S_WAIT   = 3'd2,
        S_DONE   = 3'd3,
        S_DRAIN  = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic             w_q, w_d;
    logic             signed_q, signed_d;
    logic [XLEN-1:0]  dividend_q, dividend_d;
    logic [XLEN-1:0]  divisor_q, divisor_d;
    logic [XLEN-1:0]  result_q, result_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             launch_q;
    logic             ex_ready_q;
    logic             out_valid_q;
    logic             busy_q;

    logic             accept_s;
    logic             in_signed_s;
    logic [XLEN-1:0]  ext_dvd_s;
    logic [XLEN-1:0]  ext_dvs_s;
    logic [XLEN-1:0]  min_val_s;
    logic             div_zero_s;
    logic             overflow_s;
    logic             special_s;
    logic [XLEN-1:0]  spec_quot_s;
    logic [XLEN-1:0]  spec_rem_s;
    logic             cache_hit_s;
    logic [XLEN-1:0]  cache_res_s;

    function automatic logic [XLEN-1:0] ext_operand(input logic [XLEN-1:0] src,
                                                    input logic            w,
                                                    input logic            sgn);
        logic [XLEN-1:0] res;
        if (w) begin
            res = {{(XLEN-32){sgn & src[31]}}, src[31:0]};
        end else begin
            res = src;
        end
        return res;
    endfunction

    function automatic logic [XLEN-1:0] select_result(input logic [1:0]      op,
                                                      input logic            w,
                                                      input logic [XLEN-1:0] quot,
                                                      input logic [XLEN-1:0] rem);
        logic [XLEN-1:0] res;
        res = op[1] ? rem : quot;
        if (w) begin
            res = {{(XLEN-32){res[31]}}, res[31:0]};
        end else begin
            res = res;
        end
        return res;
    endfunction

    assign accept_s    = in_valid & in_ready;
    assign in_signed_s = ~in_op[0];
    assign ext_dvd_s   = ext_operand(in_src1, in_w, in_signed_s);
    assign ext_dvs_s   = ext_operand(in_src2, in_w, in_signed_s);

    // Most negative value of the active width, as it appears after sign extension
    assign min_val_s   = in_w ? {{(XLEN-32){1'b1}}, 32'h8000_0000} : {1'b1, {(XLEN-1){1'b0}}};
    assign div_zero_s  = (ext_dvs_s == {XLEN{1'b0}});
    assign overflow_s  = in_signed_s & (ext_dvd_s == min_val_s) & (ext_dvs_s == {XLEN{1'b1}});
    assign special_s   = div_zero_s | overflow_s;
    assign spec_quot_s = div_zero_s ? {XLEN{1'b1}} : ext_dvd_s;
    assign spec_rem_s  = div_zero_s ? ext_dvd_s : {XLEN{1'b0}};

`ifdef DIV_ISSUE_CACHE_EN
    logic            cache_valid_q;
    logic [XLEN-1:0] cache_dvd_q;
    logic [XLEN-1:0] cache_dvs_q;
    logic            cache_signed_q;
    logic            cache_w_q;
    logic [XLEN-1:0] cache_quot_q;
    logic [XLEN-1:0] cache_rem_q;
    logic            cache_wr_s;

    assign cache_hit_s = cache_valid_q & (cache_dvd_q == ext_dvd_s) & (cache_dvs_q == ext_dvs_s)
                       & (cache_signed_q == in_signed_s) & (cache_w_q == in_w);
    assign cache_res_s = select_result(in_op, in_w, cache_quot_q, cache_rem_q);
    assign cache_wr_s  = (state_q == S_WAIT) & div_valid & ~flush;
`else
    assign cache_hit_s = 1'b0;
    assign cache_res_s = {XLEN{1'b0}};
`endif

    // Next-state and datapath capture for the issue/collect FSM
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        w_d        = w_q;
        signed_d   = signed_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        result_d   = result_q;
        tag_d      = tag_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    op_d       = in_op;
                    w_d        = in_w;
                    signed_d   = in_signed_s;
                    dividend_d = ext_dvd_s;
                    divisor_d  = ext_dvs_s;
                    tag_d      = in_tag;
                    if (special_s) begin
                        result_d = select_result(in_op, in_w, spec_quot_s, spec_rem_s);
                        state_d  = S_DONE;
                    end else if (cache_hit_s) begin
                        result_d = cache_res_s;
                        state_d  = S_DONE;
                    end else begin
                        state_d  = S_LAUNCH;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LAUNCH: begin
                if (flush) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (div_valid) begin
                    if (flush) begin
                        state_d = S_IDLE;
                    end else begin
                        result_d = select_result(op_q, w_q, div_quotient, div_remainder);
                        state_d  = S_DONE;
                    end
                end else if (flush) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_DONE: begin
                if (flush || out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DRAIN: begin
                if (div_valid) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, operand/result registers and registered handshake outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            op_q        <= 2'd0;
            w_q         <= 1'b0;
            signed_q    <= 1'b0;
            dividend_q  <= {XLEN{1'b0}};
            divisor_q   <= {XLEN{1'b0}};
            result_q    <= {XLEN{1'b0}};
            tag_q       <= {TAG_W{1'b0}};
            launch_q    <= 1'b0;
            ex_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef DIV_ISSUE_CACHE_EN
            cache_valid_q  <= 1'b0;
            cache_dvd_q    <= {XLEN{1'b0}};
            cache_dvs_q    <= {XLEN{1'b0}};
            cache_signed_q <= 1'b0;
            cache_w_q      <= 1'b0;
            cache_quot_q   <= {XLEN{1'b0}};
            cache_rem_q    <= {XLEN{1'b0}};
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            w_q         <= w_d;
            signed_q    <= signed_d;
            dividend_q  <= dividend_d;
            divisor_q   <= divisor_d;
            result_q    <= result_d;
            tag_q       <= tag_d;
            launch_q    <= (state_d == S_LAUNCH);
            ex_ready_q  <= (state_d == S_WAIT) || (state_d == S_DRAIN);
            out_valid_q <= (state_d == S_DONE);
            busy_q      <= (state_d != S_IDLE);
`ifdef DIV_ISSUE_CACHE_EN
            // Only a normally collected result refreshes the cache
            if (cache_wr_s) begin
                cache_valid_q  <= 1'b1;
                cache_dvd_q    <= dividend_q;
                cache_dvs_q    <= divisor_q;
                cache_signed_q <= signed_q;
                cache_w_q      <= w_q;
                cache_quot_q   <= div_quotient;
                cache_rem_q    <= div_remainder;
            end
`endif
        end
    end

    assign in_ready     = (state_q == S_IDLE) & ~flush;
    assign div_id_valid = launch_q;
    assign div_ena      = launch_q;
    assign div_signed   = signed_q;
    assign div_w        = w_q;
    assign div_dividend = dividend_q;
    assign div_divisor  = divisor_q;
    assign div_ex_ready = ex_ready_q;
    assign out_valid    = out_valid_q;
    assign out_result   = result_q;
    assign out_tag      = tag_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_div_issue.sv
// Directed bench for div_issue with a behavioural iterative-divider responder.
// Expectations follow the cache build when DIV_ISSUE_CACHE_EN is defined.
`timescale 1ns/1ps
module tb_div_issue;

`ifdef DIV_ISSUE_CACHE_EN
    localparam int CACHED = 1;
`else
    localparam int CACHED = 0;
`endif

    logic        clock, reset, flush;
    logic        in_valid, in_ready, in_w;
    logic [1:0]  in_op;
    logic [63:0] in_src1, in_src2;
    logic [4:0]  in_tag;
    logic        div_id_valid, div_ena, div_signed, div_w, div_ex_ready, div_valid;
    logic [63:0] div_dividend, div_divisor, div_quotient, div_remainder;
    logic        out_valid, out_ready, busy;
    logic [63:0] out_result;
    logic [4:0]  out_tag;

    int          checks = 0;
    int          errors = 0;
    int          launch_cnt = 0;
    int          div_lat = 10;
    int          pend_cnt;
    logic        pend;
    logic [63:0] last_dvd, last_dvs;
    logic [4:0]  next_tag;

    div_issue #(.XLEN(64), .TAG_W(5)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_w(in_w),
        .in_src1(in_src1), .in_src2(in_src2), .in_tag(in_tag),
        .div_id_valid(div_id_valid), .div_ena(div_ena), .div_signed(div_signed), .div_w(div_w),
        .div_dividend(div_dividend), .div_divisor(div_divisor), .div_ex_ready(div_ex_ready),
        .div_valid(div_valid), .div_quotient(div_quotient), .div_remainder(div_remainder),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag),
        .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Sign-magnitude reference division; avoids native signed divide of MIN by -1
    function automatic logic [63:0] mdl_div(input logic [63:0] a, input logic [63:0] b,
                                            input logic sgn, input logic rem);
        logic [63:0] ua, ub, q, r;
        logic        na, nb;
        na = sgn & a[63];
        nb = sgn & b[63];
        ua = na ? (64'd0 - a) : a;
        ub = nb ? (64'd0 - b) : b;
        if (ub == 64'd0) begin
            q = {64{1'b1}};
            r = a;
        end else begin
            q = ua / ub;
            r = ua % ub;
            if (na ^ nb) q = 64'd0 - q;
            if (na) r = 64'd0 - r;
        end
        return rem ? r : q;
    endfunction

    always @(posedge clock) begin
        if (div_id_valid) begin
            launch_cnt <= launch_cnt + 1;
            last_dvd   <= div_dividend;
            last_dvs   <= div_divisor;
        end
    end

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            div_valid     <= 1'b0;
            pend          <= 1'b0;
            pend_cnt      <= 0;
            div_quotient  <= 64'd0;
            div_remainder <= 64'd0;
        end else begin
            if (div_valid && div_ex_ready) div_valid <= 1'b0;
            if (div_id_valid) begin
                pend     <= 1'b1;
                pend_cnt <= div_lat;
            end else if (pend) begin
                if (pend_cnt == 0) begin
                    pend          <= 1'b0;
                    div_valid     <= 1'b1;
                    div_quotient  <= mdl_div(div_dividend, div_divisor, div_signed, 1'b0);
                    div_remainder <= mdl_div(div_dividend, div_divisor, div_signed, 1'b1);
                end else begin
                    pend_cnt <= pend_cnt - 1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic launch_op(input logic [1:0] op, input logic w, input logic [63:0] a, input logic [63:0] b);
        int cyc;
        cyc = 0;
        while (!in_ready && cyc < 100) begin
            @(negedge clock);
            cyc++;
        end
        in_valid = 1'b1; in_op = op; in_w = w; in_src1 = a; in_src2 = b; in_tag = next_tag;
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    task automatic do_op(input string tag, input logic [1:0] op, input logic w,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp,
                         input int exp_lat, input int exp_launch, input int hold);
        int cyc, l0;
        logic [4:0] t;
        l0 = launch_cnt;
        t  = next_tag;
        launch_op(op, w, a, b);
        next_tag = next_tag + 5'd1;
        cyc = 1;
        while (!out_valid && cyc < 200) begin
            @(negedge clock);
            cyc++;
        end
        check({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
        check({tag, "_res"}, out_result, exp);
        check({tag, "_tag"}, {59'd0, out_tag}, {59'd0, t});
        check({tag, "_launch"}, 64'(launch_cnt - l0), 64'(exp_launch));
        if (exp_lat > 0) check({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
        if (hold > 0) begin
            repeat (hold) @(negedge clock);
            check({tag, "_hold"}, {63'd0, out_valid}, 64'd1);
            check({tag, "_hold_res"}, out_result, exp);
        end
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
    endtask

    task automatic drain_wait(input string tag);
        int cyc, bad;
        cyc = 0;
        bad = 0;
        while (!div_valid && cyc < 100) begin
            if (in_ready || out_valid || !div_ex_ready || !busy) bad++;
            @(negedge clock);
            cyc++;
        end
        check({tag, "_drain_bound"}, (cyc < 100) ? 64'd1 : 64'd0, 64'd1);
        check({tag, "_drain_hold"}, 64'(bad), 64'd0);
        @(negedge clock);
        check({tag, "_drain_exit"}, {61'd0, in_ready, out_valid, busy}, 64'b100);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = 2'd0; in_w = 1'b0;
        in_src1 = 64'd0; in_src2 = 64'd0; in_tag = 5'd0; out_ready = 1'b0; next_tag = 5'd3;
        repeat (2) @(negedge clock);
        check("rst_ctl", {59'd0, out_valid, busy, div_id_valid, div_ena, div_ex_ready}, 64'd0);
        check("rst_res", out_result, 64'd0);
        check("rst_dvd", div_dividend, 64'd0);
        reset = 1'b0;
        @(negedge clock);
        check("idle_ready", {63'd0, in_ready}, 64'd1);

        do_op("div_neg",  2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, -1, 1, 0);
        do_op("rem_neg",  2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE,
              (CACHED != 0) ? 1 : -1, (CACHED != 0) ? 0 : 1, 0);
        do_op("divuw",    2'b01, 1'b1, 64'hDEAD_BEEF_0000_0007, 64'd2, 64'd3, -1, 1, 0);
        check("divuw_ext", last_dvd, 64'd7);
        check("divuw_flags", {62'd0, div_signed, div_w}, 64'b01);
        do_op("remw",     2'b10, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'hABCD_0000_0000_0002,
              64'hFFFF_FFFF_FFFF_FFFF, -1, 1, 0);
        check("remw_dvd", last_dvd, 64'hFFFF_FFFF_FFFF_FFF9);
        check("remw_dvs", last_dvs, 64'd2);
        do_op("divw",     2'b00, 1'b1, 64'h0000_0000_FFFF_FFF0, 64'd4, 64'hFFFF_FFFF_FFFF_FFFC, -1, 1, 0);
        do_op("divu_z",   2'b01, 1'b0, 64'd123, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0);
        do_op("remu_z",   2'b11, 1'b0, 64'd123, 64'd0, 64'd123, 1, 0, 0);
        do_op("divuw_z",  2'b01, 1'b1, 64'd5, 64'h0000_0001_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0);
        do_op("div_ovf",  2'b00, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
              64'h8000_0000_0000_0000, 1, 0, 0);
        do_op("remw_ovf", 2'b10, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1, 0, 0);
        do_op("divw_ovf", 2'b00, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
              64'hFFFF_FFFF_8000_0000, 1, 0, 0);
        do_op("divu_big", 2'b01, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'h7FFF_FFFF_FFFF_FFFF, -1, 1, 3);

        // Flush while idle: nothing may be accepted
        in_valid = 1'b1; in_op = 2'b00; in_w = 1'b0; in_src1 = 64'd9; in_src2 = 64'd3; flush = 1'b1;
        #1;
        check("fi_ready", {63'd0, in_ready}, 64'd0);
        @(negedge clock);
        in_valid = 1'b0; flush = 1'b0;
        check("fi_busy", {63'd0, busy}, 64'd0);

        // Flush during DONE drops the result
        launch_op(2'b01, 1'b0, 64'd9, 64'd0);
        check("fd_valid", {63'd0, out_valid}, 64'd1);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        check("fd_gone", {62'd0, out_valid, busy}, 64'd0);

        // Flush in LAUNCH: pulse still goes out, then drain
        launch_op(2'b00, 1'b0, 64'd60, 64'd6);
        check("fl_pulse", {62'd0, div_id_valid, div_ena}, 64'b11);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        drain_wait("fl");

        // Flush five cycles into WAIT
        launch_op(2'b00, 1'b0, 64'd50, 64'd5);
        repeat (6) @(negedge clock);
        check("fw_exready", {63'd0, div_ex_ready}, 64'd1);
        flush = 1'b1;
        #1;
        check("fw_ready", {63'd0, in_ready}, 64'd0);
        @(negedge clock);
        flush = 1'b0;
        drain_wait("fw");

        do_op("div_100_7", 2'b00, 1'b0, 64'd100, 64'd7, 64'd14, -1, 1, 0);
        do_op("rem_100_7", 2'b10, 1'b0, 64'd100, 64'd7, 64'd2,
              (CACHED != 0) ? 1 : -1, (CACHED != 0) ? 0 : 1, 0);

        // Asynchronous reset in the middle of an op
        launch_op(2'b00, 1'b0, 64'd100, 64'd3);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        #1;
        check("ar_ctl", {60'd0, busy, div_ex_ready, div_id_valid, out_valid}, 64'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("ar_ready", {63'd0, in_ready}, 64'd1);
        do_op("after_rst", 2'b00, 1'b0, 64'd100, 64'd7, 64'd14, -1, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
